sa_result_drain: RTL and testbench
==================================

Name: sa_result_drain

Overview:
- Sits directly downstream of the systolic-array wrapper (SA_wrapper).
- Captures the full S x C result matrix on the array's output-valid pulse into one of two ping-pong banks, then streams it out one row (C elements) per handshake to the write-back / softmax stage.
- Double buffering lets the array compute the next tile while the previous one drains; back-pressure and overflow are reported to the array controller.

Parameters:
- D_W, 16, element width in bits (fixed-point, passed through unmodified).
- S, 16, array rows = result rows per matrix.
- C, 16, array columns = elements per output row.

Ports:
- I_CLK  in  1  clock; all logic on rising edge.
- I_RST  in  1  synchronous, active-high reset.
- I_MAT_VLD  in  1  one-cycle pulse; I_MAT holds a complete result (connects to SA O_OUT_VLD).
- I_MAT  in  S*C*D_W  result matrix; element (i,j) at [(i*C+j)*D_W +: D_W].
- I_ROW_RDY  in  1  downstream ready.
- I_OVF_CLR  in  1  clears O_OVF.
- O_ROW_VLD  out  1  O_ROW holds a valid row.
- O_ROW  out  C*D_W  current row; element j at [j*D_W +: D_W] = element (O_ROW_IDX, j).
- O_ROW_IDX  out  $clog2(S)  index of the current row.
- O_ROW_LAST  out  1  current row is row S-1.
- O_FULL  out  1  both banks occupied; the controller must not issue a new matrix.
- O_OVF  out  1  sticky; a matrix was dropped.
- O_DONE  out  1  one-cycle pulse after a matrix fully drains.

Behaviour:
- Internal state: 2 banks of S*C*D_W, wr_bank (1b), rd_bank (1b), cnt (0..2), row_idx.
- Reset: cnt=0, wr_bank=rd_bank=0, row_idx=0. Outputs O_ROW_VLD=0, O_ROW_IDX=0, O_ROW_LAST=0, O_FULL=0, O_OVF=0, O_DONE=0. O_ROW is don't-care; bank contents are not cleared. A reset mid-drain abandons both banks.
- Capture:
  - When I_MAT_VLD=1 and cnt<2: I_MAT is written into bank[wr_bank], wr_bank toggles, and cnt increments (unless a drain completes in the same cycle).
  - When I_MAT_VLD=1 and cnt==2: the matrix is dropped, O_OVF is set the next cycle, and banks and pointers are unchanged.
  - A capture never overwrites the bank currently draining.
- Drain:
  - O_ROW_VLD = (cnt!=0). O_ROW = bank[rd_bank] row row_idx, driven directly from registers.
  - Handshake = O_ROW_VLD & I_ROW_RDY.
  - On handshake with row_idx<S-1: row_idx+1.
  - On handshake with row_idx==S-1: row_idx=0, rd_bank toggles, cnt decrements, and O_DONE=1 the next cycle.
  - While O_ROW_VLD=1 and I_ROW_RDY=0, O_ROW / O_ROW_IDX / O_ROW_LAST stay stable.
- Simultaneous final-row handshake and accepted capture: cnt is unchanged, both pointers toggle. Capture acceptance is judged on cnt before the update, so at cnt==2 the matrix is dropped even if the drain finishes in that cycle.
- Latency: I_MAT_VLD sampled at edge N into an empty block gives O_ROW_VLD=1 with row 0 after edge N. Sustained I_ROW_RDY=1 drains one row per cycle, so S cycles per matrix.
- Flags:
  - O_ROW_LAST = O_ROW_VLD & (row_idx==S-1).
  - O_FULL = (cnt==2), registered.
  - O_OVF: a drop has priority over I_OVF_CLR in the same cycle.
- Width rules: pure data movement, no arithmetic on elements, bit-exact passthrough.

Test Plan:
- Single matrix: reset, then I_MAT_VLD pulse with element (i,j)=16'h{i[7:0],j[7:0]}, I_ROW_RDY=1. Expect O_ROW_VLD for 16 consecutive cycles starting the cycle after capture, row k elements = 16'h0k00..16'h0k0F, O_ROW_LAST on k=15, O_DONE pulse one cycle later, then O_ROW_VLD=0.
- Back-pressure: toggle I_ROW_RDY 1,0,0,1,... during drain. Expect rows held stable while RDY=0, no row skipped or duplicated, all 16 rows delivered in order.
- Ping-pong: matrix A (all 16'h1111) then matrix B (all 16'h2222) 3 cycles later, I_ROW_RDY=0. Expect O_FULL=1 after B. Release RDY: 16 rows of 1111 then 16 rows of 2222, O_FULL drops after A's last row.
- Overflow: with O_FULL=1, pulse I_MAT_VLD with 16'h3333. Expect O_OVF=1 (sticky), drained data is A then B only. I_OVF_CLR clears it.
- Simultaneous: cnt=2, final-row handshake of A and I_MAT_VLD (C) in the same cycle. Expect C dropped, O_OVF=1. Repeat with cnt=1: capture accepted, cnt stays 1, C drains after B.
- Reset mid-drain: assert I_RST at row 7. Next cycle all outputs are at reset values. A new matrix afterwards drains from row 0 correctly.

Source files
------------

// File: rtl/sa_result_drain.sv
// Ping-pong result buffer behind the systolic array: captures a full S x C matrix
// on the array's valid pulse and streams it out one row per ready/valid handshake.
module sa_result_drain #(
    parameter int D_W = 16,
    parameter int S   = 16,
    parameter int C   = 16,
    localparam int IW = (S > 1) ? $clog2(S) : 1
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_MAT_VLD,
    input  logic [S*C*D_W-1:0] I_MAT,
    input  logic               I_ROW_RDY,
    input  logic               I_OVF_CLR,
    output logic               O_ROW_VLD,
    output logic [C*D_W-1:0]   O_ROW,
    output logic [IW-1:0]      O_ROW_IDX,
    output logic               O_ROW_LAST,
    output logic               O_FULL,
    output logic               O_OVF,
    output logic               O_DONE
);

    localparam int ROW_W = C * D_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

    logic [S*C*D_W-1:0] r_bank [2];
    logic [1:0]         r_cnt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [IW-1:0]      r_row_idx;
    logic               r_ovf;
    logic               r_done;

    logic       w_vld;
    logic       w_hs;
    logic       w_fin;
    logic       w_cap;
    logic       w_drop;
    logic [1:0] w_cnt_nxt;
    int         w_base;

    assign w_vld  = (r_cnt != 2'd0);
    assign w_hs   = w_vld & I_ROW_RDY;
    assign w_fin  = w_hs & (r_row_idx == LAST_IDX);
    // Acceptance looks at the occupancy before this cycle's drain completes.
    assign w_cap  = I_MAT_VLD & (r_cnt != 2'd2);
    assign w_drop = I_MAT_VLD & (r_cnt == 2'd2);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_cap && !w_fin)
            w_cnt_nxt = r_cnt + 2'd1;
        else if (!w_cap && w_fin)
            w_cnt_nxt = r_cnt - 2'd1;
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_cnt     <= 2'd0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_row_idx <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_fin;
            if (w_cap)
                r_wr_bank <= ~r_wr_bank;
            if (w_fin) begin
                r_rd_bank <= ~r_rd_bank;
                r_row_idx <= '0;
            end else if (w_hs) begin
                r_row_idx <= r_row_idx + 1'b1;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            else if (I_OVF_CLR)
                r_ovf <= 1'b0;
        end
    end

    // Bank storage is data only; the write bank is never the one draining.
    always_ff @(posedge I_CLK) begin
        if (w_cap)
            r_bank[r_wr_bank] <= I_MAT;
    end

    assign w_base     = int'(r_row_idx) * ROW_W;
    assign O_ROW      = r_bank[r_rd_bank][w_base +: ROW_W];
    assign O_ROW_VLD  = w_vld;
    assign O_ROW_IDX  = r_row_idx;
    assign O_ROW_LAST = w_vld & (r_row_idx == LAST_IDX);
    assign O_FULL     = (r_cnt == 2'd2);
    assign O_OVF      = r_ovf;
    assign O_DONE     = r_done;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed-plus-random bench for sa_result_drain against a queue-of-matrices model.
module tb_sa_result_drain;

    localparam int D_W = 16;
    localparam int S   = 16;
    localparam int C   = 16;
    localparam int IW  = $clog2(S);
    localparam int MW  = S * C * D_W;
    localparam int RW  = C * D_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mat_vld = 1'b0;
    logic [MW-1:0] mat = '0;
    logic          row_rdy = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          row_vld;
    logic [RW-1:0] row;
    logic [IW-1:0] row_idx;
    logic          row_last;
    logic          full;
    logic          ovf;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [MW-1:0] m_q[$];
    int            m_ridx = 0;
    bit            m_ovf  = 1'b0;
    bit            m_done = 1'b0;

    always #5 clk = ~clk;

    sa_result_drain #(.D_W(D_W), .S(S), .C(C)) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_MAT_VLD  (mat_vld),
        .I_MAT      (mat),
        .I_ROW_RDY  (row_rdy),
        .I_OVF_CLR  (ovf_clr),
        .O_ROW_VLD  (row_vld),
        .O_ROW      (row),
        .O_ROW_IDX  (row_idx),
        .O_ROW_LAST (row_last),
        .O_FULL     (full),
        .O_OVF      (ovf),
        .O_DONE     (done)
    );

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of up to two captured matrices; the head drains row by row.
    task automatic model_update(input bit r, input bit v, input logic [MW-1:0] m,
                                input bit rdy, input bit clr);
        bit hs, fin, acc, drp;
        if (r) begin
            m_q.delete();
            m_ridx = 0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
            return;
        end
        hs  = (m_q.size() != 0) && rdy;
        fin = hs && (m_ridx == S - 1);
        acc = v && (m_q.size() < 2);
        drp = v && (m_q.size() == 2);
        if (fin) begin
            void'(m_q.pop_front());
            m_ridx = 0;
        end else if (hs) begin
            m_ridx++;
        end
        if (acc)
            m_q.push_back(m);
        m_done = fin;
        if (drp)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
    endtask

    task automatic check_all();
        bit ev;
        logic [MW-1:0] head;
        ev = (m_q.size() != 0);
        chk("row_vld",  RW'(row_vld),  RW'(ev));
        chk("row_idx",  RW'(row_idx),  RW'(m_ridx));
        chk("row_last", RW'(row_last), RW'(ev && (m_ridx == S - 1)));
        chk("full",     RW'(full),     RW'(m_q.size() == 2));
        chk("ovf",      RW'(ovf),      RW'(m_ovf));
        chk("done",     RW'(done),     RW'(m_done));
        if (ev) begin
            head = m_q[0];
            chk("row_data", row, head[m_ridx*RW +: RW]);
        end
    endtask

    task automatic step(input bit v, input logic [MW-1:0] m, input bit rdy,
                        input bit clr, input bit r);
        mat_vld = v;
        mat     = m;
        row_rdy = rdy;
        ovf_clr = clr;
        rst     = r;
        @(posedge clk);
        model_update(r, v, m, rdy, clr);
        @(negedge clk);
        check_all();
        mat_vld = 1'b0;
        ovf_clr = 1'b0;
        rst     = 1'b0;
    endtask

    function automatic logic [MW-1:0] fill(input logic [D_W-1:0] val);
        logic [MW-1:0] t;
        for (int k = 0; k < S * C; k++) t[k*D_W +: D_W] = val;
        return t;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] t;
        for (int k = 0; k < MW / 32; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    logic [MW-1:0] pat, ma, mb, mc;
    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < S; i++)
            for (int j = 0; j < C; j++)
                pat[(i*C+j)*D_W +: D_W] = {8'(i), 8'(j)};
        ma = fill(16'h1111);
        mb = fill(16'h2222);
        mc = fill(16'h3333);
        @(negedge clk);

        // Reset values
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);

        // Single matrix with continuous ready
        step(1, pat, 1, 0, 0);
        for (int k = 0; k < S + 3; k++) step(0, '0, 1, 0, 0);

        // Back-pressure with a 1,0,0,1 ready pattern
        step(1, rnd_mat(), 0, 0, 0);
        for (int k = 0; k < 4 * S + 4; k++) step(0, '0, rdy_pat[k % 4], 0, 0);

        // Ping-pong with overflow, then clear
        step(1, ma, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(1, mb, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(1, mc, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        for (int k = 0; k < 2 * S + 3; k++) step(0, '0, 1, 0, 0);

        // Final-row handshake coinciding with a capture at cnt==2 (dropped)
        step(1, ma, 0, 0, 0);
        step(1, mb, 0, 0, 0);
        for (int k = 0; k < S - 1; k++) step(0, '0, 1, 0, 0);
        step(1, mc, 1, 0, 0);
        for (int k = 0; k < S + 2; k++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        // Same coincidence at cnt==1 (accepted, drains after B)
        step(1, ma, 0, 0, 0);
        step(1, mb, 0, 0, 0);
        for (int k = 0; k < 2 * S - 1; k++) step(0, '0, 1, 0, 0);
        step(1, mc, 1, 0, 0);
        for (int k = 0; k < S + 2; k++) step(0, '0, 1, 0, 0);

        // Reset mid-drain at row 7, then a fresh matrix
        step(1, rnd_mat(), 0, 0, 0);
        step(1, rnd_mat(), 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 0);
        step(1, pat, 1, 0, 0);
        for (int k = 0; k < S + 2; k++) step(0, '0, 1, 0, 0);

        // Randomised traffic
        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 9) == 0), rnd_mat(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
